// File: rtl/uncached_mem_port_pkg.sv
// Shared uncached-port definitions: FSM encoding, AXI size codes and wstrb->size decode.
// Latency: none (types and pure functions only); backpressure: not applicable.
package uncached_mem_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_RESP = 3'd5
    } ucm_state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    // The pipeline only issues right-aligned byte/half/word masks.
    function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
        case (strb)
            4'b0001: strb_to_size = SZ_B;
            4'b0011: strb_to_size = SZ_H;
            default: strb_to_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/uncached_mem_port_llsc_resv.sv
// LL/SC reservation bit plus word tag; pass is combinational from the flops and the checked tag.
// Latency: set/clear take effect the next cycle; backpressure: none, always accepts set/clr.
module uncached_llsc_resv #(
    parameter int TAG_W = 30
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             set,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr,
    input  logic [TAG_W-1:0] chk_tag,
    output logic             pass
);

    logic             llbit_q, llbit_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // A clear in the same cycle as an LL completion wins, so ERTN never leaves a stale reservation.
    always_comb begin
        llbit_d = llbit_q;
        tag_d   = tag_q;
        if (clr) begin
            llbit_d = 1'b0;
        end else if (set) begin
            llbit_d = 1'b1;
            tag_d   = set_tag;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            llbit_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            llbit_q <= llbit_d;
            tag_q   <= tag_d;
        end
    end

    assign pass = llbit_q && (tag_q == chk_tag);

endmodule

// File: rtl/uncached_mem_port.sv
// Uncached/strongly-ordered request -> single-beat AXI; min latency 3 cycles, failed SC 1 cycle.
// Backpressure: one request in flight, others ignored until IDLE; LL/SC reservation under MEM_LLSC_EN.
module uncached_mem_port
    import uncached_mem_port_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rvalid,
    input  logic                wvalid,
    input  logic                op,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                is_atom,
    input  logic                flush,
    input  logic                llbit_clr,
    output logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                wready,
    output logic                sc_ok,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [2:0]          m_arsize,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [2:0]          m_awsize,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready
);

    ucm_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                op_q, op_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                cancel_q, cancel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rready_q, rready_d;
    logic                wready_q, wready_d;
    logic                sc_ok_q, sc_ok_d;
    logic                req_acc;
    logic                sc_fail;

    assign req_acc = (state_q == ST_IDLE) && (rvalid || wvalid) && !flush;

`ifdef MEM_LLSC_EN
    logic atom_q, atom_d;
    logic resv_pass, resv_set, resv_clr;

    assign atom_d   = req_acc ? is_atom : atom_q;
    assign sc_fail  = op && is_atom && !resv_pass;
    assign resv_set = (state_q == ST_R) && m_rvalid && !op_q && atom_q && !(cancel_q || flush);
    assign resv_clr = llbit_clr || (req_acc && op && is_atom);

    always_ff @(posedge aclk) begin
        if (!aresetn) atom_q <= 1'b0;
        else          atom_q <= atom_d;
    end

    uncached_llsc_resv #(.TAG_W(ADDR_W-2)) u_resv (
        .aclk    (aclk),
        .aresetn (aresetn),
        .set     (resv_set),
        .set_tag (addr_q[ADDR_W-1:2]),
        .clr     (resv_clr),
        .chk_tag (addr[ADDR_W-1:2]),
        .pass    (resv_pass)
    );

    assign sc_ok = sc_ok_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{is_atom, llbit_clr, sc_ok_q};
    assign sc_fail    = 1'b0;
    assign sc_ok      = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cancel_d  = cancel_q;
        rdata_d   = rdata_q;
        rready_d  = 1'b0;
        wready_d  = 1'b0;
        sc_ok_d   = sc_ok_q;
        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (req_acc) begin
                    addr_d  = addr;
                    op_d    = op;
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    if (!op) begin
                        state_d = ST_AR;
                    end else if (sc_fail) begin
                        state_d  = ST_RESP;
                        wready_d = 1'b1;
                        sc_ok_d  = 1'b0;
                    end else begin
                        state_d   = ST_AW_W;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            ST_AR: begin
                if (m_arready) state_d = ST_R;
            end
            ST_R: begin
                if (m_rvalid) begin
                    rdata_d  = m_rdata >> {addr_q[1:0], 3'b000};
                    rready_d = !(cancel_q || flush);
                    state_d  = ST_RESP;
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q || m_awready;
                w_done_d  = w_done_q || m_wready;
                if (aw_done_d && w_done_d) state_d = ST_B;
            end
            ST_B: begin
                if (m_bvalid) begin
                    wready_d = !(cancel_q || flush);
                    sc_ok_d  = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                cancel_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The AXI beat cannot be aborted, so a flush only silences the completion pulse.
        if (flush && state_q != ST_IDLE && state_q != ST_RESP) cancel_d = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            op_q      <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cancel_q  <= 1'b0;
            rdata_q   <= '0;
            rready_q  <= 1'b0;
            wready_q  <= 1'b0;
            sc_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cancel_q  <= cancel_d;
            rdata_q   <= rdata_d;
            rready_q  <= rready_d;
            wready_q  <= wready_d;
            sc_ok_q   <= sc_ok_d;
        end
    end

    assign rready    = rready_q;
    assign wready    = wready_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);

    assign m_araddr  = addr_q;
    assign m_arvalid = (state_q == ST_AR);
    assign m_arsize  = SZ_W;
    assign m_rready  = (state_q == ST_R);

    assign m_awaddr  = addr_q;
    assign m_awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign m_awsize  = strb_to_size(wstrb_q);
    assign m_wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign m_wstrb   = wstrb_q << addr_q[1:0];
    assign m_wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign m_bready  = (state_q == ST_B);

endmodule

// File: tb/tb_uncached_mem_port.sv
// Directed bench for uncached_mem_port: hand-computed vectors, sampled 1 time unit after each rising edge.
module tb_uncached_mem_port;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] addr;
    logic        rvalid, wvalid, op;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        is_atom, flush, llbit_clr;
    logic        rready, wready, sc_ok, busy;
    logic [31:0] rdata;
    logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [2:0]  m_arsize, m_awsize;
    logic [3:0]  m_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    uncached_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .addr(addr), .rvalid(rvalid), .wvalid(wvalid),
        .op(op), .wstrb(wstrb), .wdata(wdata), .is_atom(is_atom), .flush(flush),
        .llbit_clr(llbit_clr), .rready(rready), .rdata(rdata), .wready(wready),
        .sc_ok(sc_ok), .busy(busy),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arsize(m_arsize),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awsize(m_awsize),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic o, input logic [3:0] s,
                       input logic [31:0] d, input logic at);
        addr    = a;
        op      = o;
        wstrb   = s;
        wdata   = d;
        is_atom = at;
        rvalid  = !o;
        wvalid  = o;
    endtask

    task automatic drop();
        rvalid  = 1'b0;
        wvalid  = 1'b0;
        is_atom = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; addr = '0; rvalid = 0; wvalid = 0; op = 0; wstrb = '0; wdata = '0;
        is_atom = 0; flush = 0; llbit_clr = 0;
        m_arready = 0; m_rdata = '0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        tick(); tick();
        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valids", {28'd0, m_arvalid, m_awvalid, m_wvalid, 1'b0}, 32'd0);
        chk("rst_readies", {29'd0, m_rready, m_bready, 1'b0}, 32'd0);
        chk("rst_done", {30'd0, rready, wready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
`ifdef MEM_LLSC_EN
        chk("rst_sc_ok", 32'(sc_ok), 32'd0);
`endif
        aresetn = 1'b1;
        tick();

        // Word read, zero-wait slave
        m_arready = 1; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        req(32'h1C000100, 0, 4'hF, 0, 0);
        tick();
        chk("rd_arvalid", 32'(m_arvalid), 32'd1);
        chk("rd_araddr", m_araddr, 32'h1C000100);
        chk("rd_arsize", 32'(m_arsize), 32'd2);
        chk("rd_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_rready_bus", {30'd0, m_rready, m_arvalid}, 32'd2);
        chk("rd_rready_early", 32'(rready), 32'd0);
        tick();
        chk("rd_rready", 32'(rready), 32'd1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        drop();
        tick();
        chk("rd_pulse_end", {30'd0, rready, busy}, 32'd0);
        m_arready = 0; m_rvalid = 0;

        // Byte write to byte lane 3, AW delayed
        m_wready = 1;
        req(32'h1C000103, 1, 4'b0001, 32'h000000A5, 0);
        tick();
        chk("bw_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        chk("bw_awaddr", m_awaddr, 32'h1C000103);
        chk("bw_wstrb", 32'(m_wstrb), 32'h8);
        chk("bw_wdata", m_wdata, 32'hA5000000);
        chk("bw_awsize", 32'(m_awsize), 32'd0);
        tick();
        chk("bw_w_dropped", {30'd0, m_awvalid, m_wvalid}, 32'd2);
        tick();
        chk("bw_aw_held", 32'(m_awvalid), 32'd1);
        m_awready = 1;
        tick();
        chk("bw_in_b", {30'd0, m_bready, m_awvalid}, 32'd2);
        chk("bw_no_early_wready", 32'(wready), 32'd0);
        m_awready = 0; m_wready = 0; m_bvalid = 1;
        tick();
        chk("bw_wready", {30'd0, wready, sc_ok}, 32'd3);
        drop(); m_bvalid = 0;
        tick();
        chk("bw_pulse_end", {30'd0, wready, busy}, 32'd0);

        // Half read from upper half
        m_arready = 1; m_rvalid = 1; m_rdata = 32'h12345678;
        req(32'h1C000102, 0, 4'hF, 0, 0);
        tick();
        chk("hr_araddr", m_araddr, 32'h1C000102);
        tick(); tick();
        chk("hr_rready", 32'(rready), 32'd1);
        chk("hr_rdata", rdata, 32'h00001234);
        drop();
        tick();
        m_arready = 0; m_rvalid = 0;

        // Flush while waiting for read data
        m_arready = 1;
        req(32'h1C000010, 0, 4'hF, 0, 0);
        tick();
        tick();
        chk("fl_in_r", 32'(m_rready), 32'd1);
        flush = 1; drop();
        tick();
        flush = 0;
        chk("fl_still_busy", {30'd0, busy, m_rready}, 32'd3);
        m_rvalid = 1; m_rdata = 32'h00000099;
        tick();
        chk("fl_no_rready", {30'd0, rready, busy}, 32'd1);
        m_rvalid = 0;
        tick();
        chk("fl_idle", {30'd0, rready, busy}, 32'd0);
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        req(32'h1C000100, 0, 4'hF, 0, 0);
        tick(); tick(); tick();
        chk("fl_next_rready", 32'(rready), 32'd1);
        chk("fl_next_rdata", rdata, 32'hCAFEF00D);
        drop();
        tick();
        m_arready = 0; m_rvalid = 0;

`ifdef MEM_LLSC_EN
        // LL then SC to the same word succeeds
        m_arready = 1; m_rvalid = 1; m_rdata = 32'h11;
        req(32'h00000080, 0, 4'hF, 0, 1);
        tick(); tick(); tick();
        chk("ll1_rready", 32'(rready), 32'd1);
        drop(); tick();
        m_awready = 1; m_wready = 1; m_bvalid = 1;
        req(32'h00000080, 1, 4'hF, 32'h55, 1);
        tick();
        chk("sc1_awvalid", 32'(m_awvalid), 32'd1);
        tick(); tick();
        chk("sc1_ok", {30'd0, wready, sc_ok}, 32'd3);
        drop(); tick();
        // LL, reservation cleared, SC fails without bus traffic
        req(32'h00000080, 0, 4'hF, 0, 1);
        tick(); tick(); tick();
        drop(); tick();
        llbit_clr = 1; tick(); llbit_clr = 0;
        req(32'h00000080, 1, 4'hF, 32'h66, 1);
        tick();
        chk("sc2_fail", {30'd0, wready, sc_ok}, 32'd2);
        chk("sc2_no_aw", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        drop(); tick();
        chk("sc2_idle", 32'(busy), 32'd0);
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        // Arm a reservation so the reset below has something to clear
        m_arready = 1; m_rvalid = 1;
        req(32'h00000084, 0, 4'hF, 0, 1);
        tick(); tick(); tick();
        drop(); tick();
        m_arready = 0; m_rvalid = 0;
`else
        // Atomic flag ignored: store goes to the bus and reports success
        m_awready = 1; m_wready = 1; m_bvalid = 1;
        req(32'h00000080, 1, 4'hF, 32'h55, 1);
        tick();
        chk("at_awvalid", 32'(m_awvalid), 32'd1);
        tick(); tick();
        chk("at_ok", {30'd0, wready, sc_ok}, 32'd3);
        drop(); tick();
        m_awready = 0; m_wready = 0; m_bvalid = 0;
`endif

        // Reset during AW_W
        req(32'h00000084, 1, 4'hF, 32'h77, 0);
        tick();
        chk("rs_aw_w", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        aresetn = 0; drop();
        tick();
        chk("rs_valids", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
        chk("rs_idle", {30'd0, busy, m_bready}, 32'd0);
        aresetn = 1;
        tick();
`ifdef MEM_LLSC_EN
        req(32'h00000084, 1, 4'hF, 32'h88, 1);
        tick();
        chk("rs_llbit_cleared", {29'd0, wready, sc_ok, m_awvalid}, 32'd4);
        drop(); tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
